// File: rtl/twophase_pkg.sv
// Shared types for the two-phase clock generator.
// Holds the FSM state enum, the timing config bundle and the zero-to-one helper.
package twophase_pkg;

  localparam int CFG_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    PH1,
    GAP12,
    PH2,
    GAP21
  } state_e;

  typedef struct packed {
    logic [CFG_W-1:0] h1;
    logic [CFG_W-1:0] h2;
    logic [CFG_W-1:0] gap;
  } cfg_t;

  // A zero-length phase or gap is stretched to one cycle.
  // This keeps the gap non-zero, so the phases never overlap.
  function automatic logic [CFG_W-1:0] nz1(
    input logic [CFG_W-1:0] v
  );
    return (v == '0) ? CFG_W'(1) : v;
  endfunction

endpackage

// File: rtl/twophase_cfg_shadow.sv
// Shadow and active timing config for the two-phase clock generator.
// Ports: clk/reset, load_i + cfg_i (shadow write), take_i (shadow->active),
//        nxt_o (value active would take this edge), act_o (active config).
module twophase_cfg_shadow
  import twophase_pkg::*;
#(
  parameter cfg_t RST_CFG = '{h1: CFG_W'(4), h2: CFG_W'(4), gap: CFG_W'(1)}
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic take_i,
  input  cfg_t cfg_i,
  output cfg_t nxt_o,
  output cfg_t act_o
);

  cfg_t sh_q;
  cfg_t act_q;
  cfg_t cfg_s;

  // Sanitised at write time, so every consumer sees non-zero fields.
  assign cfg_s.h1  = nz1(cfg_i.h1);
  assign cfg_s.h2  = nz1(cfg_i.h2);
  assign cfg_s.gap = nz1(cfg_i.gap);

  // Bypass: a load on the same edge as a take goes straight to active.
  assign nxt_o = load_i ? cfg_s : sh_q;
  assign act_o = act_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= RST_CFG;
      act_q <= RST_CFG;
    end else begin
      if (load_i) sh_q  <= cfg_s;
      if (take_i) act_q <= nxt_o;
    end
  end

endmodule

// File: rtl/twophase_clkgen.sv
// Two-phase non-overlapping clock generator (ph1/ph1b/ph2/ph2b) from clk.
// Ports: clk, reset, en, cfg_load + cfg_h1/cfg_h2/cfg_gap in;
//        ph1, ph1b, ph2, ph2b, running, period_tick out (all registered).
module twophase_clkgen
  import twophase_pkg::*;
#(
  parameter int CNT_W   = CFG_W,
  parameter int RST_H1  = 4,
  parameter int RST_H2  = 4,
  parameter int RST_GAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_h1,
  input  logic [CNT_W-1:0] cfg_h2,
  input  logic [CNT_W-1:0] cfg_gap,
  output logic             ph1,
  output logic             ph1b,
  output logic             ph2,
  output logic             ph2b,
  output logic             running,
  output logic             period_tick
);

  localparam cfg_t RST_CFG = '{
    h1:  nz1(CFG_W'(RST_H1)),
    h2:  nz1(CFG_W'(RST_H2)),
    gap: nz1(CFG_W'(RST_GAP))
  };

  state_e           state_q, state_d;
  logic [CFG_W-1:0] cnt_q, cnt_d;
  logic             take;
  cfg_t             cfg_in, nxt, act;

  logic ph1_q, ph1b_q, ph2_q, ph2b_q;
  logic run_q, tick_q;
  logic ph1_d, ph2_d, run_d, tick_d;

  assign cfg_in = '{h1: cfg_h1, h2: cfg_h2, gap: cfg_gap};

  twophase_cfg_shadow #(
    .RST_CFG(RST_CFG)
  ) u_cfg (
    .clk   (clk),
    .reset (reset),
    .load_i(cfg_load),
    .take_i(take),
    .cfg_i (cfg_in),
    .nxt_o (nxt),
    .act_o (act)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter holds remaining cycles minus one in the current state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 1'b1;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (en) begin
          state_d = PH1;
          cnt_d   = nxt.h1 - 1'b1;
          take    = 1'b1;
        end
      end
      PH1: if (cnt_q == '0) begin
        state_d = GAP12;
        cnt_d   = act.gap - 1'b1;
      end
      GAP12: if (cnt_q == '0) begin
        state_d = PH2;
        cnt_d   = act.h2 - 1'b1;
      end
      PH2: if (cnt_q == '0) begin
        state_d = GAP21;
        cnt_d   = act.gap - 1'b1;
      end
      GAP21: if (cnt_q == '0) begin
        if (en) begin
          state_d = PH1;
          cnt_d   = nxt.h1 - 1'b1;
          take    = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they line up with it.
  always_comb begin
    ph1_d  = (state_d == PH1);
    ph2_d  = (state_d == PH2);
    run_d  = (state_d != IDLE);
    tick_d = take;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph1_q  <= 1'b0;
      ph1b_q <= 1'b1;
      ph2_q  <= 1'b0;
      ph2b_q <= 1'b1;
      run_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      ph1_q  <= ph1_d;
      ph1b_q <= ~ph1_d;
      ph2_q  <= ph2_d;
      ph2b_q <= ~ph2_d;
      run_q  <= run_d;
      tick_q <= tick_d;
    end
  end

  assign ph1         = ph1_q;
  assign ph1b        = ph1b_q;
  assign ph2         = ph2_q;
  assign ph2b        = ph2b_q;
  assign running     = run_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_twophase_clkgen.sv
// Directed vector bench for twophase_clkgen.
// Per-cycle expected outputs built from hand-chosen phase/gap lengths.
module tb_twophase_clkgen;

  typedef struct {
    logic       rst;
    logic       en;
    logic       ld;
    logic [7:0] h1;
    logic [7:0] h2;
    logic [7:0] gap;
    logic       p1;
    logic       p2;
    logic       run;
    logic       tk;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_h1 = '0;
  logic [7:0] cfg_h2 = '0;
  logic [7:0] cfg_gap = '0;
  logic       ph1, ph1b, ph2, ph2b, running, period_tick;

  int   total = 0;
  int   bad = 0;
  bit   chk_on = 1'b0;
  vec_t vq[$];

  always #5 clk = ~clk;

  twophase_clkgen dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cfg_load   (cfg_load),
    .cfg_h1     (cfg_h1),
    .cfg_h2     (cfg_h2),
    .cfg_gap    (cfg_gap),
    .ph1        (ph1),
    .ph1b       (ph1b),
    .ph2        (ph2),
    .ph2b       (ph2b),
    .running    (running),
    .period_tick(period_tick)
  );

  always @(negedge clk) begin
    if (chk_on) begin
      total++;
      if (ph1b !== ~ph1 || ph2b !== ~ph2 || (ph1 & ph2) !== 1'b0) begin
        bad++;
        $display("FAIL invariant t=%0t ph1=%b ph1b=%b ph2=%b ph2b=%b",
                 $time, ph1, ph1b, ph2, ph2b);
      end
    end
  end

  task automatic add(input bit r, input bit e, input bit l,
                     input int a, input int b, input int g,
                     input bit p1, input bit p2, input bit rn,
                     input bit tk);
    vec_t v;
    v.rst = r;  v.en = e;  v.ld = l;
    v.h1 = 8'(a);  v.h2 = 8'(b);  v.gap = 8'(g);
    v.p1 = p1;  v.p2 = p2;  v.run = rn;  v.tk = tk;
    vq.push_back(v);
  endtask

  task automatic seg(input int n, input bit e, input bit p1,
                     input bit p2, input bit tk1);
    for (int i = 0; i < n; i++)
      add(0, e, 0, 0, 0, 0, p1, p2, 1, tk1 && i == 0);
  endtask

  task automatic per(input int a, input int g, input int b);
    seg(a, 1, 1, 0, 1);
    seg(g, 1, 0, 0, 0);
    seg(b, 1, 0, 1, 0);
    seg(g, 1, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input int i, input string nm,
                     input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL vec%0d %s got=%b want=%b", i, nm, act, exp);
    end
  endtask

  initial begin
    // reset state
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // defaults 4/1/4/1, then en drop in 2nd cycle of PH2
    per(4, 1, 4);
    per(4, 1, 4);
    seg(4, 1, 1, 0, 1);
    seg(1, 1, 0, 0, 0);
    seg(1, 1, 0, 1, 0);
    seg(3, 0, 0, 1, 0);
    seg(1, 0, 0, 0, 0);
    idle(3);
    // custom config loaded while idle: 3/2/5/2
    add(0, 0, 1, 3, 5, 2, 0, 0, 0, 0);
    per(3, 2, 5);
    per(3, 2, 5);
    // load h1=2 during PH2: current period untouched
    seg(3, 1, 1, 0, 1);
    seg(2, 1, 0, 0, 0);
    add(0, 1, 1, 2, 5, 2, 0, 1, 1, 0);
    seg(4, 1, 0, 1, 0);
    seg(2, 1, 0, 0, 0);
    per(2, 2, 5);
    // reset during PH1, restart on defaults
    seg(2, 1, 1, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    per(4, 1, 4);
    idle(1);
    // zero fields loaded on the PH1 entry edge (bypass)
    add(0, 1, 1, 0, 0, 0, 1, 0, 1, 1);
    seg(1, 1, 0, 0, 0);
    seg(1, 1, 0, 1, 0);
    seg(1, 1, 0, 0, 0);
    per(1, 1, 1);
    per(1, 1, 1);
    idle(2);

    foreach (vq[i]) begin
      reset    = vq[i].rst;
      en       = vq[i].en;
      cfg_load = vq[i].ld;
      cfg_h1   = vq[i].h1;
      cfg_h2   = vq[i].h2;
      cfg_gap  = vq[i].gap;
      @(posedge clk);
      #1;
      chk_on = 1'b1;
      chk(i, "ph1", ph1, vq[i].p1);
      chk(i, "ph1b", ph1b, ~vq[i].p1);
      chk(i, "ph2", ph2, vq[i].p2);
      chk(i, "ph2b", ph2b, ~vq[i].p2);
      chk(i, "running", running, vq[i].run);
      chk(i, "period_tick", period_tick, vq[i].tk);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
